serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/bpu_pkg.sv | 12 +
 rtl/bit_timer.sv | 24 ++
 rtl/serial_tx.sv | 82 ++++++++
 tb/tb_serial_tx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// bpu_pkg: shared transmitter state encoding and default parameters
package bpu_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_RELEASE
    } tx_state_t;
    localparam int DEF_N            = 1;
    localparam int DEF_CLKS_PER_BIT = 4;
endpackage

// File: rtl/bit_timer.sv
// bit_timer: free-running baud divider, tick on the last cycle of every CLKS_PER_BIT window
//   clk   system clock
//   rst   synchronous active-high reset
//   clear holds the divider at zero so the next window starts fresh
//   tick  high during the final cycle of each bit period
module bit_timer
    import bpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    assign tick  = cnt_q == W'(CLKS_PER_BIT - 1);
    assign cnt_d = (clear || tick) ? '0 : cnt_q + W'(1);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/serial_tx.sv
// serial_tx: frames one buffered word as start/LSB-first data/stop, then releases the buffer
//   clk       system clock
//   rst       synchronous active-high reset
//   data_in   word held by the upstream buffer
//   buf_ready upstream status: 1 = empty, 0 = holding a word
//   set_ready release request, high only in RELEASE
//   tx        serial line, idle high
//   busy      high outside IDLE
module serial_tx
    import bpu_pkg::*;
#(
    parameter int N            = DEF_N,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] data_in,
    input  logic         buf_ready,
    output logic         set_ready,
    output logic         tx,
    output logic         busy
);
    localparam int BW = $clog2(N + 1);
    tx_state_t     state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          tick, clear;
    // The divider only runs while a frame is on the line, so every bit period starts aligned.
    assign clear = state_q == S_IDLE || state_q == S_RELEASE;
    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        case (state_q)
            S_IDLE: if (!buf_ready) begin
                shreg_d = data_in;
                bit_d   = '0;
                state_d = S_START;
            end
            S_START: if (tick) begin
                bit_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: if (tick) begin
                shreg_d = shreg_q >> 1;
                bit_d   = bit_q == BW'(N - 1) ? '0 : bit_q + BW'(1);
                state_d = bit_q == BW'(N - 1) ? S_STOP : S_DATA;
            end
            S_STOP: if (tick) begin
                bit_d   = '0;
                state_d = S_RELEASE;
            end
            // Only an empty buffer ends the release, so a stale word is never sent twice.
            S_RELEASE: if (buf_ready) begin
                bit_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
        end
    end
    // Outputs decode registered state only; buf_ready never reaches tx combinationally.
    assign tx        = state_q == S_START ? 1'b0 : state_q == S_DATA ? shreg_q[0] : 1'b1;
    assign busy      = state_q != S_IDLE;
    assign set_ready = state_q == S_RELEASE;
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: scoreboard bench for serial_tx (N=8, CLKS_PER_BIT=4 and 1)
module tb_serial_tx;
    localparam int N   = 8;
    localparam int CPB = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       buf_ready = 1'b1;
    logic       br1 = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       tx, busy, set_ready;
    logic       tx1, busy1, sr1;
    int n_checks = 0;
    int n_fail   = 0;
    always #5 clk = ~clk;
    serial_tx #(.N(N), .CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .buf_ready(buf_ready),
        .set_ready(set_ready),
        .tx       (tx),
        .busy     (busy)
    );
    serial_tx #(.N(N), .CLKS_PER_BIT(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data1),
        .buf_ready(br1),
        .set_ready(sr1),
        .tx       (tx1),
        .busy     (busy1)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    logic [7:0] mon_q[$];
    logic [7:0] cur, got_w;
    int         cyc, errs, b, pulses = 0;
    logic       e, sr_prev = 1'b0;
    bit         in_frame = 1'b0;
    always @(negedge clk) begin
        if (set_ready && !sr_prev) pulses++;
        sr_prev = set_ready;
        if (in_frame) begin
            if (!busy) in_frame = 1'b0;
            else begin
                b = cyc / CPB;
                e = b == 0 ? 1'b0 : b == N + 1 ? 1'b1 : cur[b-1];
                if (tx !== e) errs++;
                if (cyc % CPB == CPB / 2 && b >= 1 && b <= N) got_w[b-1] = tx;
                if (cyc == (N + 2) * CPB - 1) begin
                    check("frame_bits", errs, 0);
                    check("frame_word", got_w, cur);
                    in_frame = 1'b0;
                end
                cyc++;
            end
        end else if (busy && tx == 1'b0) begin
            if (mon_q.size() == 0) begin
                check("unexpected_frame", 1, 0);
                cur = 8'h00;
            end else cur = mon_q.pop_front();
            in_frame = 1'b1;
            cyc = 1;
            errs = 0;
            got_w = 8'h00;
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] w);
        mon_q.push_back(w);
        data_in = w;
        buf_ready = 1'b0;
    endtask
    task automatic wait_rel(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!set_ready && n < 200);
        if (!set_ready) check("release_timeout", 0, 1);
    endtask
    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
    initial begin
        int n, hi, p0;
        logic [9:0] got10, exp10;
        logic [7:0] w;
        repeat (3) step();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_set_ready", set_ready, 0);
        check("rst_tx1", tx1, 1);
        rst = 1'b0;
        step();
        // single word
        send(8'hA5);
        wait_rel(n);
        check("single_latency", n, 41);
        check("single_rel_tx", tx, 1);
        check("single_rel_busy", busy, 1);
        buf_ready = 1'b1;
        step();
        check("single_idle_busy", busy, 0);
        check("single_idle_sr", set_ready, 0);
        // input churn, buffer already empty on release entry
        send(8'h5A);
        for (int i = 1; i <= 40; i++) begin
            step();
            data_in = 8'($urandom);
            buf_ready = 1'($urandom);
        end
        step();
        check("churn_sr_on", set_ready, 1);
        buf_ready = 1'b1;
        step();
        check("churn_sr_pulse", set_ready, 0);
        check("churn_idle", busy, 0);
        repeat (5) step();
        check("churn_no_restart", busy, 0);
        // back-to-back
        p0 = pulses;
        send(8'h00);
        wait_rel(n);
        check("b2b_lat0", n, 41);
        buf_ready = 1'b1;
        step();
        step();
        send(8'hFF);
        wait_rel(n);
        check("b2b_lat1", n, 41);
        buf_ready = 1'b1;
        repeat (3) step();
        check("b2b_pulses", pulses - p0, 2);
        check("b2b_queue_empty", mon_q.size(), 0);
        // slow ack
        send(8'h96);
        wait_rel(n);
        hi = 1;
        repeat (9) begin
            step();
            if (set_ready && tx && busy) hi++;
        end
        buf_ready = 1'b1;
        step();
        check("slow_hi_cycles", hi, 10);
        check("slow_sr_off", set_ready, 0);
        repeat (3) step();
        check("slow_no_start", busy, 0);
        // reset mid-frame during data bit 3
        p0 = pulses;
        send(8'h3C);
        repeat (18) step();
        check("rstmid_busy", busy, 1);
        check("rstmid_bit3", tx, 1);
        rst = 1'b1;
        step();
        check("rstmid_tx", tx, 1);
        check("rstmid_busy_off", busy, 0);
        check("rstmid_sr", set_ready, 0);
        mon_q.push_back(8'h3C);
        step();
        check("rstmid_no_release", pulses - p0, 0);
        rst = 1'b0;
        wait_rel(n);
        check("rstmid_refresh_lat", n, 41);
        buf_ready = 1'b1;
        repeat (3) step();
        check("rstmid_queue_empty", mon_q.size(), 0);
        // CLKS_PER_BIT = 1
        w = 8'h81;
        data1 = w;
        br1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            got10[i] = tx1;
            exp10[i] = i == 0 ? 1'b0 : i == 9 ? 1'b1 : w[i-1];
        end
        check("cpb1_frame", got10, exp10);
        step();
        check("cpb1_release", sr1, 1);
        br1 = 1'b1;
        step();
        check("cpb1_idle", busy1, 0);
        check("final_queue_empty", mon_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
